// File: rtl/k051962_pkg.sv
// Shared types and helpers for the K051962 tile pixel serializer.
// Optional feature macro used by this slice: K051962_FINE_SCROLL_EN.
package k051962_pkg;

  localparam int unsigned TILE_W  = 8;
  localparam int unsigned PLANES  = 4;
  localparam int unsigned COL_W   = 8;
  localparam int unsigned ROM_W   = PLANES * TILE_W;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned PIX_W   = 1 + COL_W + PLANES;

  // One output pixel with its colour attribute and valid marker
  typedef struct packed {
    logic              pvld;
    logic [COL_W-1:0]  pcol;
    logic [PLANES-1:0] pix;
  } pix_t;

  // Gather pixel n of a planar row; plane p lives in byte p, leftmost pixel in bit 7
  function automatic logic [PLANES-1:0] plane_pix(input logic [ROM_W-1:0]   rom,
                                                  input logic [PHASE_W-1:0] n,
                                                  input logic               flip);
    logic [PHASE_W-1:0] idx;
    plane_pix = '0;
    idx = flip ? n : ~n;
    for (int p = 0; p < int'(PLANES); p++) begin
      plane_pix[p] = rom[p * int'(TILE_W) + int'(idx)];
    end
  endfunction

endpackage

// File: rtl/k051962_pix_delay.sv
// Fine-scroll delay line: 8-deep pixel history advanced on each pixel enable.
// Only built when K051962_FINE_SCROLL_EN is defined.
module k051962_pix_delay
  import k051962_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  input  logic [2:0]       tap,
  output logic [PIX_W-1:0] dout_c
);

  localparam int unsigned DEPTH = 8;

  logic [PIX_W-1:0] line [DEPTH];

  // Shift the newest pixel in at stage 0; stage k holds the pixel from k enables ago
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) line[i] <= '0;
    end else if (en) begin
      line[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) line[i] <= line[i-1];
    end
  end

  // Tap select comes from a register, so the output only moves on clock edges
  assign dout_c = line[tap];

endmodule

// File: rtl/k051962_tile_shifter.sv
// K051962 tile row serializer: holding + shift register, X-flip, optional fine scroll.
// Fine scroll delay is built only when K051962_FINE_SCROLL_EN is defined.
module k051962_tile_shifter
  import k051962_pkg::pix_t;
  import k051962_pkg::plane_pix;
#(
  parameter int unsigned PLANES = 4,
  parameter int unsigned TILE_W = 8,
  parameter int unsigned COL_W  = 8
) (
  input  logic                     CK,
  input  logic                     CLn,
  input  logic                     PCE,
  input  logic                     LD,
  input  logic [PLANES*TILE_W-1:0] ROM_D,
  input  logic [COL_W-1:0]         COL,
  input  logic                     FLIPX,
  input  logic [2:0]               FSCR,
  output logic                     RDY,
  output logic [PLANES-1:0]        PIX,
  output logic [COL_W-1:0]         PCOL,
  output logic                     PVLD,
  output logic                     UNDR,
  output logic                     OVR
);

  localparam int unsigned ROM_W = PLANES * TILE_W;

  logic [2:0]       phase;
  logic [ROM_W-1:0] h_rom, s_rom;
  logic [COL_W-1:0] h_col, s_col;
  logic             h_flip, s_flip;
  logic             h_vld, s_vld;
  logic             undr_q, ovr_q;

  logic             xfer_c;
  logic             accept_c;
  logic [2:0]       next_idx_c;
  pix_t             raw_c;
  pix_t             out_c;

  assign xfer_c     = PCE & (phase == 3'd7);
  assign RDY        = ~h_vld | xfer_c;
  assign accept_c   = LD & RDY;
  assign next_idx_c = phase + 3'd1;

  // Undelayed pixel for this enable: pixel 0 of H on a transfer, else the next pixel of S
  always_comb begin
    raw_c = '0;
    if (xfer_c) begin
      if (h_vld) begin
        raw_c.pvld = 1'b1;
        raw_c.pcol = h_col;
        raw_c.pix  = plane_pix(h_rom, 3'd0, h_flip);
      end
    end else if (s_vld) begin
      raw_c.pvld = 1'b1;
      raw_c.pcol = s_col;
      raw_c.pix  = plane_pix(s_rom, next_idx_c, s_flip);
    end
  end

  // Phase counter, H/S double buffer and sticky status flags
  always_ff @(posedge CK) begin
    if (!CLn) begin
      phase  <= '0;
      h_rom  <= '0;
      h_col  <= '0;
      h_flip <= 1'b0;
      h_vld  <= 1'b0;
      s_rom  <= '0;
      s_col  <= '0;
      s_flip <= 1'b0;
      s_vld  <= 1'b0;
      undr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (PCE) phase <= phase + 3'd1;
      if (xfer_c) begin
        s_rom  <= h_rom;
        s_col  <= h_col;
        s_flip <= h_flip;
        s_vld  <= h_vld;
        if (!h_vld) undr_q <= 1'b1;
      end
      // A refill in the transfer cycle wins over the clear; S already took the old row
      if (accept_c) begin
        h_rom  <= ROM_D;
        h_col  <= COL;
        h_flip <= FLIPX;
        h_vld  <= 1'b1;
      end else if (xfer_c) begin
        h_vld  <= 1'b0;
      end
      if (LD && !RDY) ovr_q <= 1'b1;
    end
  end

`ifdef K051962_FINE_SCROLL_EN
  logic [2:0] fscr_q;

  // Scroll amount is latched at tile boundaries only
  always_ff @(posedge CK) begin
    if (!CLn) begin
      fscr_q <= '0;
    end else if (xfer_c) begin
      fscr_q <= FSCR;
    end
  end

  k051962_pix_delay u_delay (
    .clk    (CK),
    .rst_n  (CLn),
    .en     (PCE),
    .din    (raw_c),
    .tap    (fscr_q),
    .dout_c (out_c)
  );
`else
  pix_t out_q;
  logic unused_fscr;

  assign unused_fscr = ^FSCR;

  // Zero-delay output register, updated once per pixel
  always_ff @(posedge CK) begin
    if (!CLn) begin
      out_q <= '0;
    end else if (PCE) begin
      out_q <= raw_c;
    end
  end

  assign out_c = out_q;
`endif

  assign PIX  = out_c.pix;
  assign PCOL = out_c.pcol;
  assign PVLD = out_c.pvld;
  assign UNDR = undr_q;
  assign OVR  = ovr_q;

endmodule

// File: tb/tb_k051962_tile_shifter.sv
// Self-checking bench for k051962_tile_shifter against a pixel-stream reference model.
module tb_k051962_tile_shifter;

  logic        ck;
  logic        cln;
  logic        pce;
  logic        ld;
  logic [31:0] rom_d;
  logic [7:0]  col;
  logic        flipx;
  logic [2:0]  fscr;
  logic        rdy;
  logic [3:0]  pix;
  logic [7:0]  pcol;
  logic        pvld;
  logic        undr;
  logic        ovr;

  int vectors    = 0;
  int miscompares = 0;
  int cc         = 0;

  // reference model state
  int          m_phase;
  bit          mh_vld, ms_vld;
  logic [31:0] mh_rom, ms_rom;
  logic [7:0]  mh_col, ms_col;
  bit          mh_flip, ms_flip;
  bit          m_undr, m_ovr;
  int          m_d;
  int          hist [8];

  k051962_tile_shifter dut (
    .CK    (ck),
    .CLn   (cln),
    .PCE   (pce),
    .LD    (ld),
    .ROM_D (rom_d),
    .COL   (col),
    .FLIPX (flipx),
    .FSCR  (fscr),
    .RDY   (rdy),
    .PIX   (pix),
    .PCOL  (pcol),
    .PVLD  (pvld),
    .UNDR  (undr),
    .OVR   (ovr)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel n of a row straight from the plane-mapping rule
  function automatic int ref_pix(input logic [31:0] rom, input int n, input bit flip);
    int b;
    int v;
    v = 0;
    b = flip ? n : 7 - n;
    for (int p = 0; p < 4; p++) v += int'((rom >> (8 * p + b)) & 32'd1) << p;
    return v;
  endfunction

  function automatic int enc(input bit v, input logic [7:0] c, input int p);
    return v ? ((1 << 12) | (int'(c) << 4) | p) : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    mh_vld = 0; ms_vld = 0;
    m_undr = 0; m_ovr = 0;
    m_d = 0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
  endtask

  task automatic model_step(input bit rst, input bit p, input bit l);
    bit xfer, r;
    int val;
    if (rst) begin
      model_reset();
      return;
    end
    xfer = p && (m_phase == 7);
    r = !mh_vld || xfer;
    if (p) begin
      if (xfer) val = enc(mh_vld, mh_col, ref_pix(mh_rom, 0, mh_flip));
      else      val = enc(ms_vld, ms_col, ref_pix(ms_rom, m_phase + 1, ms_flip));
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = val;
    end
    if (xfer) begin
      ms_vld = mh_vld; ms_rom = mh_rom; ms_col = mh_col; ms_flip = mh_flip;
      if (!mh_vld) m_undr = 1;
`ifdef K051962_FINE_SCROLL_EN
      m_d = int'(fscr);
`endif
      mh_vld = 0;
    end
    if (l) begin
      if (r) begin
        mh_vld = 1; mh_rom = rom_d; mh_col = col; mh_flip = flipx;
      end else begin
        m_ovr = 1;
      end
    end
    if (p) m_phase = (m_phase + 1) % 8;
  endtask

  task automatic check_outputs();
    int e;
    e = hist[m_d];
    chk("pix",  32'(pix),  32'(e & 15));
    chk("pcol", 32'(pcol), 32'((e >> 4) & 255));
    chk("pvld", 32'(pvld), 32'((e >> 12) & 1));
    chk("undr", 32'(undr), 32'(m_undr));
    chk("ovr",  32'(ovr),  32'(m_ovr));
  endtask

  // One CK cycle: drive, check RDY, clock the DUT and model, check outputs
  task automatic tick(input bit rst, input bit p, input bit l);
    cln = !rst; pce = p; ld = l;
    #1;
    chk("rdy", 32'(rdy), 32'(!mh_vld || (p && m_phase == 7)));
    @(posedge ck);
    model_step(rst, p, l);
    #1;
    check_outputs();
  endtask

  // Directed tick with the nominal pixel enable every 4th CK
  task automatic tickd(input bit rst, input bit l);
    tick(rst, (cc % 4) == 3, l);
    cc++;
  endtask

  initial begin
    int guard;
    cln = 1'b0; pce = 1'b0; ld = 1'b0;
    rom_d = 32'hFF00_F00F; col = 8'h5A; flipx = 1'b0; fscr = 3'd0;

    // power-on reset and reset state
    repeat (2) @(posedge ck);
    #1;
    model_reset();
    chk("rst_rdy", 32'(rdy), 32'd1);
    check_outputs();

    // row with FLIPX = 0, then underrun on the following transfer
    cc = 0;
    tickd(0, 1);
    repeat (80) tickd(0, 0);
    chk("undr_sticky", 32'(undr), 32'd1);

    // same row with FLIPX = 1
    tickd(1, 0);
    cc = 0; flipx = 1'b1;
    tickd(0, 1);
    repeat (40) tickd(0, 0);

    // double load without a transfer: second is dropped
    tickd(1, 0);
    cc = 0; flipx = 1'b0; rom_d = 32'h1234_5678; col = 8'hC3;
    tickd(0, 1);
    rom_d = 32'hDEAD_BEEF; col = 8'h11;
    tickd(0, 1);
    chk("ovr_set", 32'(ovr), 32'd1);
    repeat (40) tickd(0, 0);

    // fine scroll 3, then a change mid-row takes effect at the next boundary
    tickd(1, 0);
    cc = 0; fscr = 3'd3; rom_d = 32'hA5C3_0FF0; col = 8'h77;
    tickd(0, 1);
    repeat (44) tickd(0, 0);
    fscr = 3'd6; rom_d = 32'h0F1E_2D3C; col = 8'h99; flipx = 1'b1;
    tickd(0, 1);
    repeat (60) tickd(0, 0);
    fscr = 3'd0;

    // reset in the middle of a valid row at phase 4
    tickd(1, 0);
    cc = 0; rom_d = 32'hFFFF_FFFF; col = 8'hE1;
    tickd(0, 1);
    guard = 0;
    while (!(ms_vld && m_phase == 4) && guard < 200) begin
      tickd(0, guard == 40);
      guard++;
    end
    chk("reach_phase4", 32'(guard < 200), 32'd1);
    tickd(1, 0);
    chk("mid_rst_pix",  32'(pix),  32'd0);
    chk("mid_rst_pcol", 32'(pcol), 32'd0);
    chk("mid_rst_pvld", 32'(pvld), 32'd0);
    chk("mid_rst_flag", 32'({undr, ovr}), 32'd0);
    chk("mid_rst_rdy",  32'(rdy),  32'd1);
    repeat (40) tickd(0, (cc % 32) == 5);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rom_d = $urandom;
      col   = 8'($urandom);
      flipx = 1'($urandom);
      if ($urandom_range(0, 15) == 0) fscr = 3'($urandom);
      tick($urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
